// File: rtl/fetch_decode.sv
// fetch_decode: RV32I-subset PC, decode and next-PC front end with sticky illegal-instruction halt
module fetch_decode #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instr,
  input  logic             instr_valid,
  input  logic             EQ,
  output logic [WIDTH-1:0] pc,
  output logic             RegWrite,
  output logic             ALUsrc,
  output logic [2:0]       ALUctrl,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [4:0]       rd,
  output logic [31:0]      ImmOp,
  output logic             halted,
  output logic [31:0]      instret
);
  typedef enum logic {RUN, HALT} state_t;
  state_t state_q;
  logic [WIDTH-1:0] pc_q, pc_d, target;
  logic [31:0] instret_q;
  logic [2:0] f3, alu_f3;
  logic [6:0] f7;
  logic legal, is_br, f3_ok, taken, bad;
  assign f3 = instr[14:12];
  assign f7 = instr[31:25];
  assign rs2 = instr[24:20];
  assign rd = instr[11:7];
  assign alu_f3 = f3 == 3'b111 ? 3'b010 : f3 == 3'b110 ? 3'b011 : f3 == 3'b010 ? 3'b101 : 3'b000;
  assign f3_ok = alu_f3 != 3'b000 || f3 == 3'b000;
  // Combinational decode of the instruction word into ALU/regfile controls
  always_comb begin
    rs1 = instr[19:15];
    ALUsrc = 1'b0;
    ALUctrl = 3'b000;
    ImmOp = {{20{instr[31]}}, instr[31:20]};
    legal = 1'b0;
    is_br = 1'b0;
    case (instr[6:0])
      7'b0010011: begin
        legal = f3_ok;
        ALUsrc = 1'b1;
        ALUctrl = alu_f3;
      end
      7'b0110011: begin
        legal = (f7 == 7'b0000000 && f3_ok) || (f7 == 7'b0100000 && f3 == 3'b000);
        ALUctrl = f7[5] ? 3'b001 : alu_f3;
      end
      7'b0110111: begin
        legal = 1'b1;
        rs1 = 5'd0;
        ALUsrc = 1'b1;
        ImmOp = {instr[31:12], 12'b0};
      end
      7'b1100011: begin
        legal = f3[2:1] == 2'b00;
        is_br = 1'b1;
        ALUctrl = 3'b001;
        ImmOp = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      default: ;
    endcase
  end
  assign taken = is_br && legal && (f3[0] ? !EQ : EQ);
  assign target = pc_q + WIDTH'($signed(ImmOp));
  assign bad = !legal || (taken && target[1]);
  assign pc_d = taken ? target : pc_q + WIDTH'(4);
  assign RegWrite = rst_n && instr_valid && state_q == RUN && legal && !is_br;
  assign pc = pc_q;
  assign instret = instret_q;
  assign halted = state_q == HALT;
  // RUN/HALT state, PC and retire counter; an illegal retire freezes everything until reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      pc_q <= RESET_PC;
      instret_q <= '0;
    end else if (state_q == RUN && instr_valid) begin
      if (bad) state_q <= HALT;
      else begin
        pc_q <= pc_d;
        instret_q <= instret_q + 32'd1;
      end
    end
  end
endmodule

// File: tb/tb_fetch_decode.sv
// tb_fetch_decode: directed table, random run against a reference model, and PC wrap check
module tb_fetch_decode;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, instr_valid, eq;
  logic [31:0] instr;
  logic [31:0] pc, ImmOp, instret, w_pc, w_ImmOp, w_instret;
  logic RegWrite, ALUsrc, halted, w_RegWrite, w_ALUsrc, w_halted;
  logic [2:0] ALUctrl, w_ALUctrl;
  logic [4:0] rs1, rs2, rd, w_rs1, w_rs2, w_rd;
  int total = 0, bad = 0;

  fetch_decode dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid), .EQ(eq),
    .pc(pc), .RegWrite(RegWrite), .ALUsrc(ALUsrc), .ALUctrl(ALUctrl),
    .rs1(rs1), .rs2(rs2), .rd(rd), .ImmOp(ImmOp), .halted(halted), .instret(instret)
  );
  fetch_decode #(.WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid), .EQ(eq),
    .pc(w_pc), .RegWrite(w_RegWrite), .ALUsrc(w_ALUsrc), .ALUctrl(w_ALUctrl),
    .rs1(w_rs1), .rs2(w_rs2), .rd(w_rd), .ImmOp(w_ImmOp), .halted(w_halted), .instret(w_instret)
  );

  localparam logic [31:0] ADDI = 32'h0050_0513;
  localparam logic [31:0] BNE  = 32'hFE05_1EE3;
  localparam logic [31:0] LUI  = 32'h1234_52B7;
  localparam logic [31:0] SUB  = 32'h4020_81B3;
  localparam logic [31:0] BEQ6 = 32'h0000_0363;

  typedef struct {
    logic rstn, valid, eqv;
    logic [31:0] w;
    logic m, mi, rw;
    logic [2:0] ctrl;
    logic src;
    logic [4:0] r1, rdx;
    logic [31:0] imm, epc, eir;
    logic eh;
  } vec_t;
  vec_t tab [18];

  typedef struct {
    logic ok, br, src;
    logic [2:0] ctl;
    logic [4:0] r1;
    logic [31:0] imm;
  } dec_t;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h expected=%h at %0t", n, a, e, $time);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic e, input logic [31:0] w);
    rst_n = r;
    instr_valid = v;
    eq = e;
    instr = w;
    #2;
  endtask

  function automatic dec_t ref_dec(input logic [31:0] w);
    dec_t d;
    logic [2:0] f = w[14:12];
    logic [2:0] ctl_of [8] = '{3'd0, 3'd0, 3'd5, 3'd0, 3'd0, 3'd0, 3'd3, 3'd2};
    logic alu_ok = f == 3'd0 || f == 3'd2 || f == 3'd6 || f == 3'd7;
    d = '{ok: 1'b0, br: 1'b0, src: 1'b0, ctl: 3'd0, r1: w[19:15], imm: 32'd0};
    if (w[6:0] == 7'h13) begin
      d.ok = alu_ok; d.src = 1'b1; d.ctl = ctl_of[f];
      d.imm = 32'($signed(w[31:20]));
    end else if (w[6:0] == 7'h33) begin
      d.ok = (w[31:25] == 7'h00 && alu_ok) || (w[31:25] == 7'h20 && f == 3'd0);
      d.ctl = w[31:25] == 7'h20 ? 3'd1 : ctl_of[f];
    end else if (w[6:0] == 7'h37) begin
      d.ok = 1'b1; d.src = 1'b1; d.r1 = 5'd0; d.imm = {w[31:12], 12'h000};
    end else if (w[6:0] == 7'h63) begin
      d.ok = f < 3'd2; d.br = 1'b1; d.ctl = 3'd1;
      d.imm = 32'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
    end
    return d;
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [2:0] pick [4] = '{3'd0, 3'd7, 3'd6, 3'd2};
    logic [2:0] f = pick[$urandom_range(0, 3)];
    logic [4:0] a = 5'($urandom), b = 5'($urandom), c = 5'($urandom);
    logic [12:0] off = 13'($signed(4 * ($urandom_range(0, 32) - 16)));
    int k = $urandom_range(0, 9);
    if ($urandom_range(0, 7) == 0) off = off + 13'd2;
    case (k)
      0, 1, 2: return {12'($urandom), a, f, c, 7'h13};
      3: return {12'($urandom), a, 3'($urandom), c, 7'h13};
      4, 5: return {($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00, b, a, f, c, 7'h33};
      6: return {20'($urandom), c, 7'h37};
      7, 8: return {off[12], off[10:5], b, a, ($urandom_range(0, 5) == 0) ? 3'd2 : 3'($urandom_range(0, 1)), off[4:1], off[11], 7'h63};
      default: return $urandom;
    endcase
  endfunction

  logic [31:0] m_pc, m_ir, tgt;
  logic m_h, tk;
  dec_t d;

  initial begin
    rst_n = 1'b0; instr_valid = 1'b1; eq = 1'b0; instr = ADDI;
    tab[0]  = '{1'b0,1'b1,1'b0,ADDI,1'b1,1'b1,1'b0,3'd0,1'b1,5'd0,5'd10,32'd5,32'h0,32'd0,1'b0};
    tab[1]  = tab[0];
    tab[2]  = '{1'b1,1'b1,1'b0,ADDI,1'b1,1'b1,1'b1,3'd0,1'b1,5'd0,5'd10,32'd5,32'h4,32'd1,1'b0};
    tab[3]  = '{1'b1,1'b1,1'b0,ADDI,1'b1,1'b1,1'b1,3'd0,1'b1,5'd0,5'd10,32'd5,32'h8,32'd2,1'b0};
    tab[4]  = '{1'b1,1'b1,1'b0,BNE,1'b1,1'b1,1'b0,3'd1,1'b0,5'd10,5'd29,32'hFFFF_FFFC,32'h4,32'd3,1'b0};
    tab[5]  = '{1'b1,1'b0,1'b0,LUI,1'b0,1'b0,1'b0,3'd0,1'b0,5'd0,5'd0,32'd0,32'h4,32'd3,1'b0};
    tab[6]  = tab[5];
    tab[7]  = tab[5];
    tab[8]  = '{1'b1,1'b1,1'b0,LUI,1'b1,1'b1,1'b1,3'd0,1'b1,5'd0,5'd5,32'h1234_5000,32'h8,32'd4,1'b0};
    tab[9]  = '{1'b1,1'b1,1'b1,BNE,1'b1,1'b1,1'b0,3'd1,1'b0,5'd10,5'd29,32'hFFFF_FFFC,32'hC,32'd5,1'b0};
    tab[10] = '{1'b1,1'b1,1'b0,ADDI,1'b1,1'b1,1'b1,3'd0,1'b1,5'd0,5'd10,32'd5,32'h10,32'd6,1'b0};
    tab[11] = '{1'b1,1'b1,1'b0,32'h0,1'b0,1'b0,1'b0,3'd0,1'b0,5'd0,5'd0,32'd0,32'h10,32'd6,1'b1};
    tab[12] = '{1'b1,1'b1,1'b0,ADDI,1'b1,1'b1,1'b0,3'd0,1'b1,5'd0,5'd10,32'd5,32'h10,32'd6,1'b1};
    tab[13] = '{1'b0,1'b1,1'b0,ADDI,1'b1,1'b1,1'b0,3'd0,1'b1,5'd0,5'd10,32'd5,32'h0,32'd0,1'b0};
    tab[14] = tab[2];
    tab[15] = '{1'b1,1'b1,1'b0,SUB,1'b1,1'b0,1'b1,3'd1,1'b0,5'd1,5'd3,32'd0,32'h8,32'd2,1'b0};
    tab[16] = '{1'b1,1'b1,1'b0,BEQ6,1'b1,1'b1,1'b0,3'd1,1'b0,5'd0,5'd6,32'd6,32'hC,32'd3,1'b0};
    tab[17] = '{1'b1,1'b1,1'b1,BEQ6,1'b1,1'b1,1'b0,3'd1,1'b0,5'd0,5'd6,32'd6,32'hC,32'd3,1'b1};
    @(negedge clk);
    for (int i = 0; i < 18; i++) begin
      drive(tab[i].rstn, tab[i].valid, tab[i].eqv, tab[i].w);
      chk($sformatf("tab%0d.RegWrite", i), 32'(RegWrite), 32'(tab[i].rw));
      if (tab[i].m) begin
        chk($sformatf("tab%0d.ALUctrl", i), 32'(ALUctrl), 32'(tab[i].ctrl));
        chk($sformatf("tab%0d.ALUsrc", i), 32'(ALUsrc), 32'(tab[i].src));
        chk($sformatf("tab%0d.rs1", i), 32'(rs1), 32'(tab[i].r1));
        chk($sformatf("tab%0d.rd", i), 32'(rd), 32'(tab[i].rdx));
      end
      if (tab[i].mi) chk($sformatf("tab%0d.ImmOp", i), ImmOp, tab[i].imm);
      @(posedge clk); #1;
      chk($sformatf("tab%0d.pc", i), pc, tab[i].epc);
      chk($sformatf("tab%0d.instret", i), instret, tab[i].eir);
      chk($sformatf("tab%0d.halted", i), 32'(halted), 32'(tab[i].eh));
      @(negedge clk);
    end
    m_pc = 32'd0; m_ir = 32'd0; m_h = 1'b1;
    for (int i = 0; i < 600; i++) begin
      drive((i == 0 || $urandom_range(0, 9) == 0) ? 1'b0 : 1'b1, $urandom_range(0, 6) != 0,
            1'($urandom), rnd_instr());
      d = ref_dec(instr);
      chk("rnd.RegWrite", 32'(RegWrite), 32'(rst_n && instr_valid && !m_h && d.ok && !d.br));
      chk("rnd.rs2", 32'(rs2), 32'(instr[24:20]));
      chk("rnd.rd", 32'(rd), 32'(instr[11:7]));
      if (d.ok) begin
        chk("rnd.ALUctrl", 32'(ALUctrl), 32'(d.ctl));
        chk("rnd.ALUsrc", 32'(ALUsrc), 32'(d.src));
        chk("rnd.rs1", 32'(rs1), 32'(d.r1));
        if (d.src || d.br) chk("rnd.ImmOp", ImmOp, d.imm);
      end
      tk = d.ok && d.br && (instr[12] ? !eq : eq);
      tgt = m_pc + d.imm;
      @(posedge clk);
      if (!rst_n) begin
        m_pc = 32'd0; m_ir = 32'd0; m_h = 1'b0;
      end else if (!m_h && instr_valid) begin
        if (!d.ok || (tk && tgt[1])) m_h = 1'b1;
        else begin
          m_pc = tk ? tgt : m_pc + 32'd4;
          m_ir = m_ir + 32'd1;
        end
      end
      #1;
      chk("rnd.pc", pc, m_pc);
      chk("rnd.instret", instret, m_ir);
      chk("rnd.halted", 32'(halted), 32'(m_h));
      @(negedge clk);
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 1'b0, ADDI);
      chk("wrap.rst.RegWrite", 32'(w_RegWrite), 32'd0);
      @(posedge clk); #1;
      chk("wrap.rst.pc", w_pc, 32'hFFFF_FFFC);
      chk("wrap.rst.instret", w_instret, 32'd0);
      @(negedge clk);
    end
    drive(1'b1, 1'b1, 1'b0, ADDI);
    chk("wrap.RegWrite", 32'(w_RegWrite), 32'd1);
    @(posedge clk); #1;
    chk("wrap.pc", w_pc, 32'h0);
    chk("wrap.instret", w_instret, 32'd1);
    chk("wrap.halted", 32'(w_halted), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_decode.md
# fetch_decode

Front end of the single-cycle core: holds the program counter, presents it to instruction memory, decodes the returned RV32I word into the control and operand fields consumed by `reg_alu_top` (`RegWrite`, `ALUsrc`, `ALUctrl`, `rs1`, `rs2`, `rd`, `ImmOp`), and computes the next PC from the `EQ` flag fed back from the ALU. It also keeps a retired-instruction counter and a sticky halt state for illegal encodings.

## Interface

Parameters:
- `WIDTH`, 32: PC, instruction and immediate width.
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `instr`  in  32  instruction word at `pc`, combinational read from instruction memory.
- `instr_valid`  in  1  `instr` is valid this cycle.
- `EQ`  in  1  ALU equality flag, same cycle.
- `pc`  out  WIDTH  current PC, registered.
- `RegWrite`  out  1  register-file write enable.
- `ALUsrc`  out  1  1 = `ImmOp` is ALU operand 2.
- `ALUctrl`  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
- `rs1`, `rs2`, `rd`  out  5 each  register addresses.
- `ImmOp`  out  32  sign-extended immediate.
- `halted`  out  1  sticky illegal-instruction halt, registered.
- `instret`  out  32  retired-instruction count, registered.

## Operation

- Two states: RUN and HALT. Reset enters RUN. RUN → HALT on an illegal instruction retiring. HALT exits only via reset.
- Decode is combinational from `instr`. `rs2` = instr[24:20], `rd` = instr[11:7].
  - OP-IMM (0010011): f3 000 addi/add, 111 andi/and, 110 ori/or, 010 slti/slt. `rs1` = instr[19:15], I-imm, `ALUsrc`=1, `RegWrite`=1.
  - OP (0110011): f3 000 with f7 0000000 add, 0100000 sub. f3 111/110/010 with f7 0 map to and/or/slt. `rs1` = instr[19:15], `ALUsrc`=0, `RegWrite`=1.
  - LUI (0110111): `rs1`=0, `ImmOp`={instr[31:12],12'b0}, add, `ALUsrc`=1, `RegWrite`=1.
  - BRANCH (1100011): f3 000 beq, 001 bne. `rs1` = instr[19:15], B-imm, sub, `ALUsrc`=0, `RegWrite`=0.
  - Any other encoding, including 0x00000000, is illegal.
- `RegWrite` is forced to 0 whenever any of the following holds: `rst_n`=0, `instr_valid`=0, `halted`=1, the instruction is illegal, or the instruction is a misaligned taken branch.
- Next PC, taken when RUN and `instr_valid`=1:
  - taken branch (beq with `EQ`=1, or bne with `EQ`=0): `pc`+`ImmOp`;
  - otherwise: `pc`+4.
  - All PC arithmetic is modulo 2^WIDTH. 0xFFFF_FFFC + 4 = 0.
- A taken-branch target with bit 1 set is treated as illegal: PC does not update and the block enters HALT.
- `instret` increments by 1 per legal instruction retired while RUN with `instr_valid`=1. It wraps at 2^32.

## Timing

- Reset (`rst_n`=0 at an edge) sets `pc`=`RESET_PC`, `halted`=0, `instret`=0 and state RUN. While `rst_n` is low, decoded outputs still follow `instr`, but `RegWrite`=0.
- Reset overrides everything, including HALT and a branch in flight.
- Single-cycle operation: `instr` → decode → `EQ` → next-PC is combinational, and `pc` updates at the next edge. Retire latency is 1 cycle.
- Stall (`instr_valid`=0): `pc` and `instret` hold, and `RegWrite`=0.
- Illegal instruction with `instr_valid`=1:
  - that cycle `RegWrite`=0;
  - at the next edge `pc` holds, `halted` becomes 1 and `instret` does not increment;
  - thereafter `pc`, `instret` and `halted` are frozen and `RegWrite`=0.

## Test plan

- Reset: hold `rst_n`=0 for 2 cycles with `instr`=0x00500513 and `instr_valid`=1 → `pc`=0, `RegWrite`=0, `instret`=0, `halted`=0.
- addi x10,x0,5 (0x00500513) at `pc`=0 → `rs1`=0, `rd`=10, `ImmOp`=5, `ALUsrc`=1, `ALUctrl`=000, `RegWrite`=1; next cycle `pc`=4, `instret`=1.
- bne x10,x0,-4 (0xFE051EE3) at `pc`=8 → `ImmOp`=0xFFFFFFFC, `ALUctrl`=001, `RegWrite`=0. With `EQ`=0, next `pc`=4; with `EQ`=1, next `pc`=0xC.
- Stall then LUI:
  - `instr_valid`=0 for 3 cycles at `pc`=4 → `pc` stays 4, `instret` unchanged, `RegWrite`=0.
  - Then lui x5,0x12345 (0x123452B7) → `rs1`=0, `rd`=5, `ImmOp`=0x12345000, `ALUsrc`=1, `RegWrite`=1.
- Illegal 0x00000000 at `pc`=0x10 → `RegWrite`=0 that cycle, then `halted`=1 and `pc`=0x10 held. Subsequent valid addi has no effect; one `rst_n`=0 cycle restores `pc`=`RESET_PC` and `halted`=0.
- Wrap: `RESET_PC`=0xFFFFFFFC, addi retired → `pc`=0x00000000, `instret`=1.
